totp_digit_extract: RTL and testbench
=====================================

TOTP_DIGIT_EXTRACT -- requirements
Module: totp_digit_extract

Interface
REQ-001 SHALL have parameter IN_W, default 31, meaning width of the truncated HOTP/TOTP value (1..32).
REQ-002 SHALL have parameter DIGITS, default 6, meaning number of decimal digits produced (1..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request to convert value.
REQ-006 SHALL have port value, input, IN_W, the binary code to convert.
REQ-007 SHALL have port sel, input, 3, the digit select; 0 selects the least significant digit.
REQ-008 SHALL have port ready, output, 1, result valid.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse on conversion completion.
REQ-010 SHALL have port busy, output, 1, conversion in progress.
REQ-011 SHALL have port bcd, output, 4, the selected digit.
REQ-012 SHALL have port segs, output, 7, the selected digit in 7-segment form; bit0=a through bit6=g, active-high.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL respond to start=1 in IDLE or DONE as follows: latch value, clear the DIGITS*4-bit BCD register, set bit counter=0, and go to SHIFT.
REQ-015 SHALL perform one sequential double-dabble step per cycle in SHIFT:
- add 3 to every BCD nibble that is >=5;
- then shift left one bit, taking the value MSB first.
REQ-016 SHALL discard the carry out of the top nibble, so the result equals value mod 10^DIGITS.
REQ-017 SHALL leave SHIFT for DONE after exactly IN_W SHIFT cycles.
REQ-018 SHALL have the following latency:
- start sampled at edge T;
- ready=1 and done=1 in the cycle following edge T+IN_W;
- done is high for that single cycle only.
REQ-019 SHALL hold ready=1 in DONE until the next accepted start or rst.
REQ-020 SHALL assert busy=1 exactly while in SHIFT.
REQ-021 SHALL ignore start while in SHIFT; the conversion in progress completes unchanged.
REQ-022 SHALL, on start=1 in DONE, drop ready on the next cycle and begin a new conversion; a back-to-back restart is allowed.
REQ-023 SHALL drive bcd and segs combinationally from sel and the stored result.
REQ-024 SHALL drive bcd=4'hF and segs=7'h00 when ready=0 or sel>=DIGITS.
REQ-025 SHALL use these segment codes for digits 0-9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
REQ-026 SHALL use value bits [IN_W-1:0] only and apply no sign interpretation.

Reset
REQ-027 SHALL, with rst=1 at an edge, force the following, also when in the middle of a conversion:
- state IDLE;
- BCD register, counter and latched value cleared;
- ready=0, done=0, busy=0, bcd=4'hF, segs=7'h00.
REQ-028 SHALL give rst priority over a simultaneous start; that start is not accepted.

Configuration
REQ-029 SHALL use the macro TOTP_SEG_DECODER_EN to select the segment decoder build:
- defined: segs follows REQ-023 to REQ-025;
- undefined: segs is tied to 7'h00, the decoder logic is absent, and bcd, ready, done and busy are unchanged.

Verification
REQ-030 SHALL cover this scenario: IN_W=31, DIGITS=6, value=0x7FFFFFFF, pulse start -> ready rises 32 cycles after the start edge; sel=0..5 gives bcd 7,4,6,3,8,4; sel=0 gives segs=0x07.
REQ-031 SHALL cover this scenario: DIGITS=8, value=1234567 -> sel=7 gives bcd=0 and segs=0x3F; sel=0 gives bcd=7. With DIGITS=6 -> sel=5 gives bcd=2, and sel=6 gives bcd=F, segs=0x00.
REQ-032 SHALL cover this scenario: start with value=999999, then start with value=5 ten cycles later -> the second start is ignored; the result is 999999 and done pulses exactly once.
REQ-033 SHALL cover this scenario: assert rst at SHIFT cycle 15 -> next cycle ready=0, busy=0, bcd=F; a subsequent start with value=0 gives all digits 0 after 32 cycles.
REQ-034 SHALL cover this scenario: start held high continuously from DONE -> ready drops for 31 cycles each conversion, and done pulses every 32 cycles.
REQ-035 SHALL cover this scenario: build without TOTP_SEG_DECODER_EN, value=42 -> segs=0x00 for all sel; sel=1 gives bcd=4 and sel=0 gives bcd=2.

Source files
------------

// File: rtl/totp_digit_extract.sv
// Sequential double-dabble converter for a truncated HOTP/TOTP code, with per-digit readout.
// Define TOTP_SEG_DECODER_EN to build the 7-segment decoder; otherwise segs is tied low.
//
// state  | meaning
// IDLE   | no result held, waiting for start
// SHIFT  | one double-dabble step per cycle, IN_W cycles total
// DONE   | result valid, ready high until restart or rst
module totp_digit_extract #(
    parameter int IN_W   = 31,
    parameter int DIGITS = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    input  logic [2:0]      sel,
    output logic            ready,
    output logic            done,
    output logic            busy,
    output logic [3:0]      bcd,
    output logic [6:0]      segs
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_val;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [BCD_W-1:0]  w_adj;
    logic              w_last;
    logic              w_accept;
    logic [3:0]        w_nib;

    assign w_last   = (r_cnt == CNT_W'(IN_W - 1));
    assign w_accept = start && (r_state != S_SHIFT);

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (start)  w_state_nxt = S_SHIFT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The top nibble's carry falls off the shift, giving value mod 10^DIGITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_val   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_val <= value;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_val[IN_W-1]};
                r_val <= r_val << 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_done <= 1'b1;
            end
        end
    end

    assign ready = (r_state == S_DONE);
    assign busy  = (r_state == S_SHIFT);
    assign done  = r_done;

    always_comb begin
        w_nib = 4'hF;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel == 3'(i)) w_nib = r_bcd[i*4 +: 4];
        end
    end

    assign bcd = ready ? w_nib : 4'hF;

`ifdef TOTP_SEG_DECODER_EN
    always_comb begin
        segs = 7'h00;
        case (bcd)
            4'd0: segs = 7'h3F;
            4'd1: segs = 7'h06;
            4'd2: segs = 7'h5B;
            4'd3: segs = 7'h4F;
            4'd4: segs = 7'h66;
            4'd5: segs = 7'h6D;
            4'd6: segs = 7'h7D;
            4'd7: segs = 7'h07;
            4'd8: segs = 7'h7F;
            4'd9: segs = 7'h6F;
            default: segs = 7'h00;
        endcase
    end
`else
    assign segs = 7'h00;
`endif

endmodule

// File: tb/tb_totp_digit_extract.sv
// Directed bench for totp_digit_extract: a 6-digit and an 8-digit instance share inputs.
module tb_totp_digit_extract;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [30:0] value = '0;
    logic [2:0]  sel = '0;

    logic        ready6, done6, busy6;
    logic [3:0]  bcd6;
    logic [6:0]  segs6;
    logic        ready8, done8, busy8;
    logic [3:0]  bcd8;
    logic [6:0]  segs8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    totp_digit_extract #(.IN_W(31), .DIGITS(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .value(value), .sel(sel),
        .ready(ready6), .done(done6), .busy(busy6), .bcd(bcd6), .segs(segs6)
    );

    totp_digit_extract #(.IN_W(31), .DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .value(value), .sel(sel),
        .ready(ready8), .done(done8), .busy(busy8), .bcd(bcd8), .segs(segs8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(input int d);
`ifdef TOTP_SEG_DECODER_EN
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
`else
        return (d < 0) ? 7'h7F : 7'h00;
`endif
    endfunction

    task automatic pulse_start(input logic [30:0] v);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready6 && n < 40) begin
            tick();
            n++;
        end
        check("wait_ready", ready6, 1'b1);
    endtask

    initial begin
        int exp_a [6] = '{7, 4, 6, 3, 8, 4};
        int done_cnt;
        int low_cnt;
        int first_done;
        int second_done;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", ready6, 1'b0);
        check("rst_busy",  busy6,  1'b0);
        check("rst_done",  done6,  1'b0);
        check("rst_bcd",   bcd6,   4'hF);
        check("rst_segs",  segs6,  7'h00);

        // 0x7FFFFFFF: latency and digits
        pulse_start(31'h7FFF_FFFF);
        check("lat_busy0", busy6, 1'b1);
        low_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ready6) low_cnt++;
        end
        check("lat_early_ready", low_cnt, 0);
        tick();
        check("lat_ready", ready6, 1'b1);
        check("lat_done",  done6,  1'b1);
        check("lat_busy",  busy6,  1'b0);
        tick();
        check("lat_done_clear", done6,  1'b0);
        check("lat_ready_hold", ready6, 1'b1);
        for (int s = 0; s < 6; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("max_bcd_sel%0d", s), bcd6, exp_a[s]);
        end
        sel = 3'd0;
        #1;
        check("max_segs_sel0", segs6, seg_exp(7));

        // 1234567 on both widths
        pulse_start(31'd1234567);
        wait_ready();
        sel = 3'd7; #1;
        check("d8_bcd_sel7",  bcd8,  4'd0);
        check("d8_segs_sel7", segs8, seg_exp(0));
        check("d6_bcd_sel7",  bcd6,  4'hF);
        sel = 3'd6; #1;
        check("d8_bcd_sel6",  bcd8,  4'd1);
        check("d6_bcd_sel6",  bcd6,  4'hF);
        check("d6_segs_sel6", segs6, 7'h00);
        sel = 3'd5; #1;
        check("d6_bcd_sel5",  bcd6,  4'd2);
        sel = 3'd0; #1;
        check("d8_bcd_sel0",  bcd8,  4'd7);
        check("d6_bcd_sel0",  bcd6,  4'd7);

        // start during SHIFT is ignored
        pulse_start(31'd999999);
        done_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                value = 31'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (i == 10) check("ign_busy", busy6, 1'b1);
            if (done6) done_cnt++;
        end
        check("ign_done_cnt", done_cnt, 1);
        check("ign_ready", ready6, 1'b1);
        for (int s = 0; s < 6; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("ign_bcd_sel%0d", s), bcd6, 4'd9);
        end

        // reset mid-conversion, then convert zero
        pulse_start(31'd123456);
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel = 3'd0; #1;
        check("midrst_ready", ready6, 1'b0);
        check("midrst_busy",  busy6,  1'b0);
        check("midrst_bcd",   bcd6,   4'hF);
        rst = 1'b1;
        start = 1'b1;
        value = 31'd77;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", busy6, 1'b0);
        pulse_start(31'd0);
        for (int i = 0; i < 30; i++) tick();
        check("zero_not_yet", ready6, 1'b0);
        tick();
        check("zero_ready", ready6, 1'b1);
        for (int s = 0; s < 6; s++) begin
            sel = 3'(s);
            #1;
            check($sformatf("zero_bcd_sel%0d", s), bcd6, 4'd0);
        end

        // start held high from DONE
        value = 31'd42;
        start = 1'b1;
        done_cnt = 0;
        low_cnt = 0;
        first_done = -1;
        second_done = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!ready6) low_cnt++;
            if (done6) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        check("hold_done_cnt", done_cnt, 2);
        check("hold_low_cnt", low_cnt, 62);
        check("hold_period", second_done - first_done, 32);
        check("hold_first", first_done, 31);

        // value 42 readout
        check("v42_ready", ready6, 1'b1);
        sel = 3'd1; #1;
        check("v42_bcd_sel1", bcd6, 4'd4);
        check("v42_segs_sel1", segs6, seg_exp(4));
        sel = 3'd0; #1;
        check("v42_bcd_sel0", bcd6, 4'd2);
        check("v42_segs_sel0", segs6, seg_exp(2));
        sel = 3'd2; #1;
        check("v42_bcd_sel2", bcd6, 4'd0);
        check("v42_segs_sel2", segs6, seg_exp(0));
        sel = 3'd7; #1;
        check("v42_segs_sel7", segs6, 7'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
